fp_pack: RTL and testbench

Multi-cycle IEEE-754 packer/rounder for the float execute stage. It takes the 65-bit internal float format produced by the unpack stage, plus guard/sticky bits and a rounding mode, and returns a rounded single- or double-precision word with exception flags. Subnormal results are denormalized by an iterative one-bit-per-cycle right shifter. It sits at the tail of every FP arithmetic unit, ahead of FP register writeback.

---
 rtl/fp_pack_if.sv | 43 ++++
 rtl/fp_pack.sv | 227 ++++++++++++++++++++++
 tb/tb_fp_pack.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pack_if.sv
// Request/response bundle for fp_pack: the input handshake with the internal float operand,
// and the output handshake with the packed word and exception flags.
interface fp_pack_if;
    logic        fp_pack_i_valid;
    logic        fp_pack_o_ready;
    logic [64:0] fp_pack_i_result;
    logic [1:0]  fp_pack_i_grs;
    logic [9:0]  fp_pack_i_class;
    logic [1:0]  fp_pack_i_fmt;
    logic [2:0]  fp_pack_i_rm;
    logic        fp_pack_o_valid;
    logic        fp_pack_i_ready;
    logic [63:0] fp_pack_o_data;
    logic [4:0]  fp_pack_o_flags;

    modport master (
        output fp_pack_i_valid,
        input  fp_pack_o_ready,
        output fp_pack_i_result,
        output fp_pack_i_grs,
        output fp_pack_i_class,
        output fp_pack_i_fmt,
        output fp_pack_i_rm,
        input  fp_pack_o_valid,
        output fp_pack_i_ready,
        input  fp_pack_o_data,
        input  fp_pack_o_flags
    );

    modport slave (
        input  fp_pack_i_valid,
        output fp_pack_o_ready,
        input  fp_pack_i_result,
        input  fp_pack_i_grs,
        input  fp_pack_i_class,
        input  fp_pack_i_fmt,
        input  fp_pack_i_rm,
        output fp_pack_o_valid,
        input  fp_pack_i_ready,
        output fp_pack_o_data,
        output fp_pack_o_flags
    );
endinterface

// File: rtl/fp_pack.sv
// Multi-cycle IEEE-754 single/double packer and rounder with a one-bit-per-cycle denormalizer.
// Define FP_PACK_NANBOX_EN to drive o_data[63:32] all-ones (NaN-boxed) for single results.
module fp_pack (
    input logic      fp_pack_i_clk,
    input logic      fp_pack_i_rst_n,
    fp_pack_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, OUT} state_t;

`ifdef FP_PACK_NANBOX_EN
    localparam logic [31:0] SGL_HI = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] SGL_HI = 32'h0000_0000;
`endif

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    function automatic logic f_round_inc(input logic [2:0] rm, input logic sign,
                                         input logic lsb, input logic g, input logic s);
        logic inc;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (g | s);
            RM_RUP:  inc = ~sign & (g | s);
            RM_RMM:  inc = g;
            default: inc = g & (s | lsb);
        endcase
        return inc;
    endfunction

    // Overflow goes to infinity only when rounding away from zero in the result's direction.
    function automatic logic [63:0] f_ovf_result(input logic dbl, input logic [2:0] rm,
                                                 input logic sign);
        logic to_inf;
        case (rm)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = sign;
            RM_RUP:  to_inf = ~sign;
            default: to_inf = 1'b1;
        endcase
        if (dbl)
            return to_inf ? {sign, 11'h7FF, 52'd0} : {sign, 11'h7FE, {52{1'b1}}};
        else
            return to_inf ? {SGL_HI, sign, 8'hFF, 23'd0} : {SGL_HI, sign, 8'hFE, {23{1'b1}}};
    endfunction

    state_t      r_state, w_state_nxt;
    logic        r_pend, w_pend_nxt;
    logic [63:0] r_data, w_data_nxt;
    logic [4:0]  r_flags, w_flags_nxt;

    logic [64:0] r_res;
    logic [1:0]  r_grs;
    logic        r_dbl;
    logic [2:0]  r_rm;
    logic        r_snan, r_nan, r_inf, r_zero, r_neg_sp;

    logic [52:0] r_sig, w_sig_nxt;
    logic        r_g, w_g_nxt;
    logic        r_s, w_s_nxt;
    logic        r_tiny, w_tiny_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;

    logic        w_accept;
    logic        w_sign;
    logic [11:0] w_exp;
    logic [51:0] w_frac;

    assign bus.fp_pack_o_ready = (r_state == IDLE) && !r_pend;
    assign bus.fp_pack_o_valid = (r_state == OUT);
    assign bus.fp_pack_o_data  = r_data;
    assign bus.fp_pack_o_flags = r_flags;

    assign w_accept = bus.fp_pack_i_valid && bus.fp_pack_o_ready;
    assign w_sign   = r_res[64];
    assign w_exp    = r_res[63:52];
    assign w_frac   = r_res[51:0];

    logic [52:0] w_sig_ld;
    logic        w_g_ld, w_s_ld, w_sub;
    logic [12:0] w_sub_dist;
    logic [5:0]  w_cnt_ld;

    // Single keeps 24 significand bits in the low end of the shared 53-bit register.
    always_comb begin
        if (r_dbl) begin
            w_sig_ld   = {1'b1, w_frac};
            w_g_ld     = r_grs[1];
            w_s_ld     = r_grs[0];
            w_sub      = (w_exp <= 12'h400);
            w_sub_dist = 13'h401 - {1'b0, w_exp};
            w_cnt_ld   = (w_sub_dist > 13'd54) ? 6'd54 : w_sub_dist[5:0];
        end else begin
            w_sig_ld   = {29'd0, 1'b1, w_frac[51:29]};
            w_g_ld     = w_frac[28];
            w_s_ld     = (|w_frac[27:0]) | r_grs[0] | r_grs[1];
            w_sub      = (w_exp <= 12'h780);
            w_sub_dist = 13'h781 - {1'b0, w_exp};
            w_cnt_ld   = (w_sub_dist > 13'd25) ? 6'd25 : w_sub_dist[5:0];
        end
    end

    logic        w_inc, w_carry, w_nx, w_ovf;
    logic [53:0] w_sum;
    logic [12:0] w_texp;
    logic [63:0] w_rnd_data;
    logic [4:0]  w_rnd_flags;

    // A denormalized significand that carries into the hidden bit yields exponent field 1.
    always_comb begin
        w_inc   = f_round_inc(r_rm, w_sign, r_sig[0], r_g, r_s);
        w_sum   = {1'b0, r_sig} + {53'd0, w_inc};
        w_nx    = r_g | r_s;
        w_carry = r_dbl ? w_sum[53] : w_sum[24];
        w_texp  = {1'b0, w_exp} - (r_dbl ? 13'h400 : 13'h780) + {12'd0, w_carry};
        w_ovf   = ~r_tiny & (r_dbl ? (w_texp >= 13'd2047) : (w_texp >= 13'd255));
        if (w_ovf) begin
            w_rnd_data  = f_ovf_result(r_dbl, r_rm, w_sign);
            w_rnd_flags = 5'b00101;
        end else begin
            if (r_dbl)
                w_rnd_data = {w_sign, (r_tiny ? {10'd0, w_sum[52]} : w_texp[10:0]), w_sum[51:0]};
            else
                w_rnd_data = {SGL_HI, w_sign, (r_tiny ? {7'd0, w_sum[23]} : w_texp[7:0]),
                              w_sum[22:0]};
            w_rnd_flags = {3'b000, r_tiny & w_nx, w_nx};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_data_nxt  = r_data;
        w_flags_nxt = r_flags;
        w_sig_nxt   = r_sig;
        w_g_nxt     = r_g;
        w_s_nxt     = r_s;
        w_tiny_nxt  = r_tiny;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (r_pend) begin
                    w_pend_nxt = 1'b0;
                    if (r_nan) begin
                        w_data_nxt  = r_dbl ? 64'h7FF8_0000_0000_0000 : {SGL_HI, 32'h7FC0_0000};
                        w_flags_nxt = {r_snan, 4'b0000};
                        w_state_nxt = OUT;
                    end else if (r_inf) begin
                        w_data_nxt  = r_dbl ? {r_neg_sp, 11'h7FF, 52'd0}
                                            : {SGL_HI, r_neg_sp, 8'hFF, 23'd0};
                        w_flags_nxt = 5'd0;
                        w_state_nxt = OUT;
                    end else if (r_zero) begin
                        w_data_nxt  = r_dbl ? {r_neg_sp, 63'd0} : {SGL_HI, r_neg_sp, 31'd0};
                        w_flags_nxt = 5'd0;
                        w_state_nxt = OUT;
                    end else begin
                        w_sig_nxt   = w_sig_ld;
                        w_g_nxt     = w_g_ld;
                        w_s_nxt     = w_s_ld;
                        w_tiny_nxt  = w_sub;
                        w_cnt_nxt   = w_cnt_ld;
                        w_state_nxt = w_sub ? SHIFT : ROUND;
                    end
                end else if (w_accept) begin
                    w_pend_nxt = 1'b1;
                end
            end
            SHIFT: begin
                w_s_nxt   = r_s | r_g;
                w_g_nxt   = r_sig[0];
                w_sig_nxt = {1'b0, r_sig[52:1]};
                w_cnt_nxt = r_cnt - 6'd1;
                if (r_cnt == 6'd1)
                    w_state_nxt = ROUND;
            end
            ROUND: begin
                w_data_nxt  = w_rnd_data;
                w_flags_nxt = w_rnd_flags;
                w_state_nxt = OUT;
            end
            OUT: begin
                if (bus.fp_pack_i_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge fp_pack_i_clk or negedge fp_pack_i_rst_n) begin
        if (!fp_pack_i_rst_n) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
            r_data  <= 64'd0;
            r_flags <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_data  <= w_data_nxt;
            r_flags <= w_flags_nxt;
        end
    end

    always_ff @(posedge fp_pack_i_clk) begin
        if (w_accept) begin
            r_res    <= bus.fp_pack_i_result;
            r_grs    <= bus.fp_pack_i_grs;
            r_dbl    <= |bus.fp_pack_i_fmt;
            r_rm     <= bus.fp_pack_i_rm;
            r_snan   <= bus.fp_pack_i_class[8];
            r_nan    <= bus.fp_pack_i_class[8] | bus.fp_pack_i_class[9];
            r_inf    <= bus.fp_pack_i_class[0] | bus.fp_pack_i_class[7];
            r_zero   <= bus.fp_pack_i_class[3] | bus.fp_pack_i_class[4];
            r_neg_sp <= bus.fp_pack_i_class[0] | bus.fp_pack_i_class[3];
        end
        r_sig  <= w_sig_nxt;
        r_g    <= w_g_nxt;
        r_s    <= w_s_nxt;
        r_tiny <= w_tiny_nxt;
        r_cnt  <= w_cnt_nxt;
    end

endmodule

// File: tb/tb_fp_pack.sv
// Bench for fp_pack: directed cases, randomized operations against an arithmetic reference,
// output backpressure and reset abort in the middle of denormalization.
`timescale 1ns/1ps
module tb_fp_pack;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_pack_if u_if();

    fp_pack u_dut (
        .fp_pack_i_clk   (clk),
        .fp_pack_i_rst_n (rst_n),
        .bus             (u_if)
    );

`ifdef FP_PACK_NANBOX_EN
    localparam logic [31:0] HI = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] HI = 32'h0000_0000;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: keep the top p bits of the exact value, compare the discarded remainder against half an ulp.
    function automatic void ref_pack(input logic [64:0] res, input logic [1:0] grs,
                                     input logic [9:0] cls, input logic [1:0] fmt,
                                     input logic [2:0] rm_in, output logic [63:0] d,
                                     output logic [4:0] fl, output int lat);
        bit dbl, sgn, st, above, tie, inexact, up, to_inf;
        int p, te, k, drop, emax, rm;
        logic [63:0] x, kept, rem, half, one_p;
        dbl = (fmt != 2'd0);
        sgn = res[64];
        rm  = (rm_in > 3'd4) ? 0 : int'(rm_in);
        fl  = 5'd0;
        lat = 1;
        d   = 64'd0;
        if (cls[8] || cls[9]) begin
            d  = dbl ? 64'h7FF8000000000000 : {HI, 32'h7FC00000};
            fl = {cls[8], 4'd0};
            return;
        end
        if (cls[0] || cls[7]) begin
            d = dbl ? {cls[0], 11'h7FF, 52'd0} : {HI, cls[0], 8'hFF, 23'd0};
            return;
        end
        if (cls[3] || cls[4]) begin
            d = dbl ? {cls[3], 63'd0} : {HI, cls[3], 31'd0};
            return;
        end
        p    = dbl ? 53 : 24;
        emax = dbl ? 2047 : 255;
        te   = int'(res[63:52]) - (dbl ? 1024 : 1920);
        k    = 0;
        if (te <= 0) k = (1 - te > p + 1) ? p + 1 : 1 - te;
        lat  = 2 + k;
        x    = {10'd0, 1'b1, res[51:0], grs[1]};
        st   = grs[0];
        drop = 54 - p + k;
        kept = x >> drop;
        rem  = x & ((64'd1 << drop) - 64'd1);
        half = 64'd1 << (drop - 1);
        inexact = (rem != 64'd0) || st;
        above   = (rem > half) || ((rem == half) && st);
        tie     = (rem == half) && !st;
        case (rm)
            1: up = 1'b0;
            2: up = sgn && inexact;
            3: up = !sgn && inexact;
            4: up = above || tie;
            default: up = above || (tie && kept[0]);
        endcase
        kept  = kept + 64'(up);
        one_p = 64'd1 << (p - 1);
        if (k > 0) begin
            d  = dbl ? {sgn, 11'(kept >= one_p), kept[51:0]}
                     : {HI, sgn, 8'(kept >= one_p), kept[22:0]};
            fl = {3'b000, inexact, inexact};
        end else begin
            if (kept >= (one_p << 1)) begin
                kept = kept >> 1;
                te++;
            end
            if (te >= emax) begin
                case (rm)
                    1: to_inf = 1'b0;
                    2: to_inf = sgn;
                    3: to_inf = !sgn;
                    default: to_inf = 1'b1;
                endcase
                if (dbl) d = to_inf ? {sgn, 11'h7FF, 52'd0} : {sgn, 11'h7FE, {52{1'b1}}};
                else     d = to_inf ? {HI, sgn, 8'hFF, 23'd0} : {HI, sgn, 8'hFE, {23{1'b1}}};
                fl = 5'b00101;
            end else begin
                d  = dbl ? {sgn, 11'(te), kept[51:0]} : {HI, sgn, 8'(te), kept[22:0]};
                fl = {4'b0000, inexact};
            end
        end
    endfunction

    task automatic wait_ready(input string tag);
        int waited = 0;
        while (u_if.fp_pack_o_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, "_rdy"}, 64'(u_if.fp_pack_o_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [64:0] res, input logic [1:0] grs,
                          input logic [9:0] cls, input logic [1:0] fmt, input logic [2:0] rm,
                          input logic [63:0] exp_d, input logic [4:0] exp_fl,
                          input int exp_lat, input int hold);
        int lat;
        wait_ready(tag);
        u_if.fp_pack_i_result = res;
        u_if.fp_pack_i_grs    = grs;
        u_if.fp_pack_i_class  = cls;
        u_if.fp_pack_i_fmt    = fmt;
        u_if.fp_pack_i_rm     = rm;
        u_if.fp_pack_i_valid  = 1'b1;
        u_if.fp_pack_i_ready  = 1'b0;
        @(posedge clk); #1;
        u_if.fp_pack_i_valid  = 1'b0;
        u_if.fp_pack_i_result = ~res;
        u_if.fp_pack_i_grs    = ~grs;
        u_if.fp_pack_i_class  = ~cls;
        u_if.fp_pack_i_fmt    = ~fmt;
        u_if.fp_pack_i_rm     = ~rm;
        check({tag, "_busy"}, 64'(u_if.fp_pack_o_ready), 64'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (u_if.fp_pack_o_valid !== 1'b1 && lat < 100);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, u_if.fp_pack_o_data, exp_d);
        check({tag, "_flags"}, 64'(u_if.fp_pack_o_flags), 64'(exp_fl));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_data"}, u_if.fp_pack_o_data, exp_d);
            check({tag, "_hold_ctl"},
                  64'({u_if.fp_pack_o_valid, u_if.fp_pack_o_ready, u_if.fp_pack_o_flags}),
                  64'({1'b1, 1'b0, exp_fl}));
        end
        u_if.fp_pack_i_ready = 1'b1;
        @(posedge clk); #1;
        u_if.fp_pack_i_ready = 1'b0;
        check({tag, "_retire"}, 64'({u_if.fp_pack_o_valid, u_if.fp_pack_o_ready}), 64'b01);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [64:0] res;
        logic [1:0]  grs, fmt;
        logic [2:0]  rm;
        logic [9:0]  cls;
        logic [51:0] frac;
        logic [63:0] exp_d;
        logic [4:0]  exp_fl;
        int          exp_lat, e, sel, vld_seen;
        logic [9:0]  fin_cls [4] = '{10'h002, 10'h004, 10'h020, 10'h040};

        rst_n                 = 1'b0;
        u_if.fp_pack_i_valid  = 1'b0;
        u_if.fp_pack_i_ready  = 1'b0;
        u_if.fp_pack_i_result = '0;
        u_if.fp_pack_i_grs    = '0;
        u_if.fp_pack_i_class  = '0;
        u_if.fp_pack_i_fmt    = '0;
        u_if.fp_pack_i_rm     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 64'(u_if.fp_pack_o_valid), 64'd0);
        check("reset_data", u_if.fp_pack_o_data, 64'd0);
        check("reset_flags", 64'(u_if.fp_pack_o_flags), 64'd0);
        check("reset_ready", 64'(u_if.fp_pack_o_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("s_one", {1'b0, 12'h7FF, 52'd0}, 2'b00, 10'h040, 2'd0, 3'd0,
               {HI, 32'h3F800000}, 5'b00000, 2, 0);
        run_op("s_tie_rne", {1'b0, 12'h7FF, 52'h0000010000000}, 2'b00, 10'h040, 2'd0, 3'd0,
               {HI, 32'h3F800000}, 5'b00001, 2, 0);
        run_op("s_tie_rup", {1'b0, 12'h7FF, 52'h0000010000000}, 2'b00, 10'h040, 2'd0, 3'd3,
               {HI, 32'h3F800001}, 5'b00001, 2, 0);
        run_op("d_ovf_rne", {1'b0, 12'hBFF, 52'd0}, 2'b00, 10'h040, 2'd1, 3'd0,
               64'h7FF0000000000000, 5'b00101, 2, 0);
        run_op("d_ovf_rtz", {1'b0, 12'hBFF, 52'd0}, 2'b00, 10'h040, 2'd1, 3'd1,
               64'h7FEFFFFFFFFFFFFF, 5'b00101, 2, 0);
        run_op("s_minsub", {1'b0, 12'h76A, 52'd0}, 2'b00, 10'h040, 2'd0, 3'd0,
               {HI, 32'h00000001}, 5'b00000, 25, 0);
        run_op("s_snan", {1'b0, 12'hFFF, 52'd1}, 2'b00, 10'h100, 2'd0, 3'd0,
               {HI, 32'h7FC00000}, 5'b10000, 1, 0);
        run_op("d_negzero", {1'b1, 12'h000, 52'd0}, 2'b00, 10'h008, 2'd2, 3'd0,
               64'h8000000000000000, 5'b00000, 1, 0);
        run_op("s_backpr", {1'b0, 12'h7FF, 52'd0}, 2'b00, 10'h040, 2'd0, 3'd0,
               {HI, 32'h3F800000}, 5'b00000, 2, 5);

        // Abort an operation while it is still denormalizing.
        wait_ready("abort");
        u_if.fp_pack_i_result = {1'b0, 12'h76A, 52'd0};
        u_if.fp_pack_i_grs    = 2'b00;
        u_if.fp_pack_i_class  = 10'h040;
        u_if.fp_pack_i_fmt    = 2'd0;
        u_if.fp_pack_i_rm     = 3'd0;
        u_if.fp_pack_i_valid  = 1'b1;
        @(posedge clk); #1;
        u_if.fp_pack_i_valid  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy", 64'(u_if.fp_pack_o_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(u_if.fp_pack_o_valid), 64'd0);
        check("abort_data", u_if.fp_pack_o_data, 64'd0);
        check("abort_flags", 64'(u_if.fp_pack_o_flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", 64'(u_if.fp_pack_o_ready), 64'd1);
        vld_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (u_if.fp_pack_o_valid === 1'b1) vld_seen++;
        end
        check("abort_no_pulse", 64'(vld_seen), 64'd0);
        run_op("post_abort", {1'b1, 12'h800, 52'd0}, 2'b00, 10'h040, 2'd0, 3'd0,
               {HI, 32'hC0000000}, 5'b00000, 2, 0);

        for (int n = 0; n < 300; n++) begin
            fmt = 2'($urandom_range(0, 3));
            rm  = 3'($urandom_range(0, 7));
            grs = 2'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 15));
            case (sel)
                0: cls = 10'h100;
                1: cls = 10'h200;
                2: cls = 10'h080;
                3: cls = 10'h001;
                4: cls = 10'h010;
                5: cls = 10'h008;
                default: cls = fin_cls[$urandom_range(0, 3)];
            endcase
            case ($urandom_range(0, 3))
                0: e = ((fmt == 2'd0) ? 'h780 : 'h400) + int'($urandom_range(0, 60)) - 50;
                1: e = 'h7FF + int'($urandom_range(0, 200)) - 100;
                2: e = ((fmt == 2'd0) ? 'h87E : 'hBFE) + int'($urandom_range(0, 3)) - 1;
                default: e = int'($urandom_range(0, 4095));
            endcase
            frac = ($urandom_range(0, 3) == 0) ? {52{1'b1}} : 52'({$urandom(), $urandom()});
            res  = {1'($urandom_range(0, 1)), 12'(e), frac};
            ref_pack(res, grs, cls, fmt, rm, exp_d, exp_fl, exp_lat);
            run_op("rnd", res, grs, cls, fmt, rm, exp_d, exp_fl, exp_lat,
                   int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
